irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 4, SHALL set the number of interrupt sources (1..8); source 0 is the timer irq.
REQ-002 Parameter BASE_ADDR, default 32'h40000020, SHALL set the base of the controller's MMIO register window.
REQ-003 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 Port src_irq  input  NUM_SRC  SHALL carry level interrupt lines; bit 0 is the timer irq.
REQ-006 Port Address  input  32  SHALL be the CPU data-bus address.
REQ-007 Port Write_data  input  32  SHALL be the CPU store data.
REQ-008 Port MemWrite  input  1  SHALL be the CPU store strobe.
REQ-009 Port Read_data  output  32  SHALL return register contents combinationally from Address; 0 when unmapped.
REQ-010 Port int_req  output  1  SHALL request an interrupt from the pipeline.
REQ-011 Port int_vec  output  3  SHALL give the source index being requested.
REQ-012 Port int_ack  input  1  SHALL be the pipeline's one-cycle acceptance of int_req.

Function
REQ-013 Registers, word offsets from BASE_ADDR: 0x0 IER (RW, NUM_SRC bits); 0x4 IPR (R; write-1-clear); 0x8 ISR in-service (R); 0xC current vector (R); 0x10 EOI (W, any data).
REQ-014 A 0->1 transition of src_irq[i] (registered copy vs. current) SHALL set IPR[i] on the following clock edge.
REQ-015 Set and write-1-clear of the same IPR bit in one cycle: set SHALL win.
REQ-016 FSM states IDLE, REQ, SERVICE; encoding 2 bits, IDLE=0.
REQ-017 IDLE->REQ when IPR&IER != 0; int_vec SHALL latch the lowest-index pending-enabled source on that edge.
REQ-018 In REQ, int_req=1 and int_vec SHALL stay stable until int_ack or withdrawal.
REQ-019 REQ->SERVICE on int_ack: ISR[int_vec] set, IPR[int_vec] cleared, same edge.
REQ-020 Withdrawal: if the latched source's IPR or IER bit clears while in REQ without int_ack, SHALL return to prior state (IDLE or SERVICE), int_req low next cycle; int_ack in the same cycle SHALL win.
REQ-021 SERVICE->IDLE on EOI write when ISR becomes zero; EOI SHALL clear the lowest-index set ISR bit.
REQ-022 EOI write in IDLE or REQ SHALL be ignored.
REQ-023 int_ack while not in REQ SHALL be ignored.
REQ-024 Latency: src edge at cycle N -> IPR set N+1 -> int_req high N+2.

Reset
REQ-025 On reset: IER=0, IPR=0, ISR=0, state=IDLE, int_req=0, int_vec=0, edge registers=0; reset mid-request SHALL drop int_req immediately (asynchronously).

Configuration
REQ-026 Macro IRQ_CTRL_NEST_EN defined: SERVICE->REQ SHALL occur when a pending-enabled source has lower index than every set ISR bit; multiple ISR bits may be set.
REQ-027 Macro undefined: no REQ while any ISR bit is set; ISR holds at most one bit.

Structure
REQ-028 Package irq_ctrl_pkg SHALL hold register offsets, FSM state constants and the NUM_SRC default.
REQ-029 Sub-module irq_prio_enc SHALL implement the lowest-index-wins priority encoder (valid flag + index), instanced for pending selection and ISR clearing.

Verification
REQ-030 Reset, IER=4'b0001, src_irq[0] 0->1 at cycle N -> int_req=1, int_vec=0 at N+2; int_ack -> ISR=0x1, IPR=0x0; EOI -> IDLE.
REQ-031 IER=0xF, src 2 and src 1 rise same cycle -> int_vec=1; after ack+EOI -> int_vec=2 requested.
REQ-032 In REQ for src 3, write IPR=0x8 -> int_req low next cycle, state IDLE; repeat with int_ack in same cycle -> ISR=0x8.
REQ-033 With IRQ_CTRL_NEST_EN: service src 2, src 0 rises -> int_req, int_vec=0, ack -> ISR=0x5; EOI -> ISR=0x4; without macro -> no int_req until EOI.
REQ-034 Src edge coincident with IPR write-1-clear of same bit -> IPR bit reads 1; reset asserted in REQ -> int_req=0 same cycle, all registers read 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map offsets,
// FSM state encoding, default source count and a small one-hot helper.
package irq_ctrl_pkg;

  // Default number of interrupt sources (legal range 1..8, source 0 = timer)
  localparam int unsigned NUM_SRC_DEFAULT = 4;

  // Register offsets from the controller base address
  localparam logic [31:0] OFF_IER = 32'h0000_0000;
  localparam logic [31:0] OFF_IPR = 32'h0000_0004;
  localparam logic [31:0] OFF_ISR = 32'h0000_0008;
  localparam logic [31:0] OFF_VEC = 32'h0000_000C;
  localparam logic [31:0] OFF_EOI = 32'h0000_0010;

  // Controller FSM states, IDLE must encode as zero
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // One-hot decode of a 3-bit source index into an 8-bit mask
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any request bit is set
// and the index of the lowest set bit.
module irq_prio_enc #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan upward; the first set bit found is kept
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with edge-detected level sources,
// enable/pending/in-service registers and an IDLE/REQ/SERVICE handshake FSM.
// Optional nesting of higher-priority (lower-index) sources during service is
// enabled by defining IRQ_CTRL_NEST_EN; the default build serves one at a time.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC   = NUM_SRC_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [31:0]        Address,
  input  logic [31:0]        Write_data,
  input  logic               MemWrite,
  output logic [31:0]        Read_data,
  output logic               int_req,
  output logic [2:0]         int_vec,
  input  logic               int_ack
);

  irq_state_t         state;
  irq_state_t         ret_state;
  logic [NUM_SRC-1:0] ier;
  logic [NUM_SRC-1:0] ipr;
  logic [NUM_SRC-1:0] isr;
  logic [NUM_SRC-1:0] src_q;

  logic [31:0]        offset;
  logic               wr_ier;
  logic               wr_ipr;
  logic               wr_eoi;
  logic [NUM_SRC-1:0] wdata;

  logic               pend_valid;
  logic [2:0]         pend_idx;
  logic               isr_valid;
  logic [2:0]         isr_idx;

  logic [7:0]         vec_oh8;
  logic [7:0]         isr_oh8;
  logic [NUM_SRC-1:0] vec_mask;
  logic [NUM_SRC-1:0] isr_mask;

  logic               ack_take;
  logic               eoi_take;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [NUM_SRC-1:0] eoi_mask;
  logic [NUM_SRC-1:0] ier_next;
  logic [NUM_SRC-1:0] ipr_next;
  logic [NUM_SRC-1:0] isr_next;
  logic               withdraw;

  logic               unused_ok;

  assign unused_ok = ^{Write_data, isr_valid};

  // Bus address decode relative to the register window base
  always_comb begin
    offset = Address - BASE_ADDR;
    wdata  = Write_data[NUM_SRC-1:0];
    wr_ier = MemWrite && (offset == OFF_IER);
    wr_ipr = MemWrite && (offset == OFF_IPR);
    wr_eoi = MemWrite && (offset == OFF_EOI);
  end

  // Combinational register read-back, zero for unmapped or write-only offsets
  always_comb begin
    Read_data = '0;
    case (offset)
      OFF_IER: Read_data[NUM_SRC-1:0] = ier;
      OFF_IPR: Read_data[NUM_SRC-1:0] = ipr;
      OFF_ISR: Read_data[NUM_SRC-1:0] = isr;
      OFF_VEC: Read_data[2:0]         = int_vec;
      default: Read_data = '0;
    endcase
  end

  irq_prio_enc #(.W(NUM_SRC)) u_pend_enc (
    .req   (ipr & ier),
    .valid (pend_valid),
    .idx   (pend_idx)
  );

  irq_prio_enc #(.W(NUM_SRC)) u_isr_enc (
    .req   (isr),
    .valid (isr_valid),
    .idx   (isr_idx)
  );

  // Next-state values for the enable, pending and in-service registers
  always_comb begin
    vec_oh8  = onehot8(int_vec);
    isr_oh8  = onehot8(isr_idx);
    vec_mask = vec_oh8[NUM_SRC-1:0];
    isr_mask = isr_oh8[NUM_SRC-1:0];
    ack_take = (state == ST_REQ) && int_ack;
    eoi_take = (state == ST_SERVICE) && wr_eoi;
    rise     = src_irq & ~src_q;
    w1c_mask = wr_ipr   ? wdata    : '0;
    ack_mask = ack_take ? vec_mask : '0;
    eoi_mask = eoi_take ? isr_mask : '0;
    ier_next = wr_ier ? wdata : ier;
    // A new edge re-sets the bit even when cleared by write or by ack
    ipr_next = (ipr & ~w1c_mask & ~ack_mask) | rise;
    isr_next = (isr | ack_mask) & ~eoi_mask;
    // Judged on next-cycle values so int_req drops on the clearing edge
    withdraw = ~|(ipr_next & ier_next & vec_mask);
  end

  // Register state: edge-detect copy, enable, pending and in-service bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      ier   <= '0;
      ipr   <= '0;
      isr   <= '0;
    end else begin
      src_q <= src_irq;
      ier   <= ier_next;
      ipr   <= ipr_next;
      isr   <= isr_next;
    end
  end

  // Request handshake FSM with registered int_req/int_vec
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      int_req   <= 1'b0;
      int_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            state     <= ST_REQ;
            ret_state <= ST_IDLE;
            int_req   <= 1'b1;
            int_vec   <= pend_idx;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state   <= ST_SERVICE;
            int_req <= 1'b0;
          end else if (withdraw) begin
            state   <= ret_state;
            int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eoi_take && (isr_next == '0)) begin
            state <= ST_IDLE;
          end
`ifdef IRQ_CTRL_NEST_EN
          else if (!eoi_take && pend_valid && (pend_idx < isr_idx)) begin
            state     <= ST_REQ;
            ret_state <= ST_SERVICE;
            int_req   <= 1'b1;
            int_vec   <= pend_idx;
          end
`endif
        end
        default: begin
          state   <= ST_IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected values, a negedge
// monitor pops and compares them against register reads or int_req/int_vec.
module tb_irq_ctrl;

  localparam logic [31:0] B = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_irq;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        int_req;
  logic [2:0]  int_vec;
  logic        int_ack;

  irq_ctrl #(.NUM_SRC(4), .BASE_ADDR(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_irq    (src_irq),
    .Address    (Address),
    .Write_data (Write_data),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_ack    (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_obs;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  logic obs_valid = 1'b0;
  logic done      = 1'b0;
  logic done_seen = 1'b0;
  int   errors    = 0;
  int   checks    = 0;

  // Monitor: compare DUT output against the oldest expected entry
  always @(negedge clk) begin
    chk_t        it;
    logic [31:0] act;
    if (obs_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL monitor: strobe with empty scoreboard");
      end else begin
        it  = sb.pop_front();
        act = it.is_obs ? {28'b0, int_req, int_vec} : Read_data;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_and_strobe(input bit is_obs, input logic [31:0] exp, input string name);
    chk_t it;
    it.is_obs = is_obs;
    it.exp    = exp;
    it.name   = name;
    sb.push_back(it);
    obs_valid = 1'b1;
    @(negedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic chk_reg(input logic [31:0] off, input logic [31:0] exp, input string name);
    Address = B + off;
    push_and_strobe(1'b0, exp, name);
  endtask

  task automatic chk_obs(input logic req, input logic [2:0] vec, input string name);
    push_and_strobe(1'b1, {28'b0, req, vec}, name);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    Address    = B + off;
    Write_data = data;
    MemWrite   = 1'b1;
    tick();
    MemWrite   = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; Address = B; Write_data = '0;
    MemWrite = 1'b0; int_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and unmapped reads
    chk_reg(32'h0, 32'h0, "rst_ier");
    chk_reg(32'h4, 32'h0, "rst_ipr");
    chk_reg(32'h8, 32'h0, "rst_isr");
    chk_reg(32'hC, 32'h0, "rst_vec");
    chk_obs(1'b0, 3'd0, "rst_req");
    wr(32'h0, 32'hF);
    chk_reg(32'h14, 32'h0, "unmapped_hi");
    chk_reg(32'hFFFF_FFFC, 32'h0, "unmapped_lo");

    // Timer source: two-cycle latency, ack, EOI back to idle
    wr(32'h0, 32'h1);
    chk_reg(32'h0, 32'h1, "ier_w");
    tick();
    src_irq = 4'b0001;
    tick();
    chk_obs(1'b0, 3'd0, "lat_n1");
    chk_obs(1'b1, 3'd0, "lat_n2");
    chk_reg(32'h4, 32'h1, "ipr_timer");
    ack();
    chk_reg(32'h8, 32'h1, "isr_timer");
    chk_reg(32'h4, 32'h0, "ipr_after_ack");
    chk_obs(1'b0, 3'd0, "req_after_ack");
    wr(32'h10, 32'h0);
    chk_reg(32'h8, 32'h0, "isr_after_eoi");
    chk_obs(1'b0, 3'd0, "idle_no_reedge");
    ack();
    chk_reg(32'h8, 32'h0, "ack_in_idle");
    src_irq = '0;

    // Two sources together: lowest index first, then the other
    wr(32'h0, 32'hF);
    tick();
    src_irq = 4'b0110;
    tick(); tick();
    chk_obs(1'b1, 3'd1, "prio_vec1");
    chk_reg(32'h4, 32'h6, "ipr_both");
    chk_reg(32'hC, 32'h1, "vec_reg");
    ack();
    chk_reg(32'h8, 32'h2, "isr_src1");
    chk_reg(32'h4, 32'h4, "ipr_src2_left");
    chk_obs(1'b0, 3'd1, "no_req_in_service");
    wr(32'h10, 32'h0);
    chk_obs(1'b0, 3'd1, "idle_after_eoi");
    chk_obs(1'b1, 3'd2, "next_vec2");
    ack();
    chk_reg(32'h8, 32'h4, "isr_src2");
    wr(32'h10, 32'h0);
    chk_reg(32'h8, 32'h0, "isr_clear2");
    src_irq = '0;

    // Withdrawal by IPR write-1-clear, and ack winning over withdrawal
    tick();
    src_irq = 4'b1000;
    tick(); tick();
    chk_obs(1'b1, 3'd3, "req_src3");
    wr(32'h10, 32'h0);
    chk_obs(1'b1, 3'd3, "eoi_in_req_ignored");
    chk_reg(32'h8, 32'h0, "isr_eoi_in_req");
    wr(32'h4, 32'h8);
    chk_obs(1'b0, 3'd3, "withdraw_drop");
    chk_reg(32'h4, 32'h0, "withdraw_ipr");
    src_irq = '0;
    tick();
    src_irq = 4'b1000;
    tick(); tick();
    chk_obs(1'b1, 3'd3, "req_src3_again");
    Address = B + 32'h4; Write_data = 32'h8; MemWrite = 1'b1; int_ack = 1'b1;
    tick();
    MemWrite = 1'b0; int_ack = 1'b0;
    chk_reg(32'h8, 32'h8, "ack_beats_withdraw");
    chk_obs(1'b0, 3'd3, "req_low_after_ack");
    wr(32'h10, 32'h0);
    chk_reg(32'h8, 32'h0, "isr_clear3");
    src_irq = '0;

    // Higher-priority source arriving during service
    tick();
    src_irq = 4'b0100;
    tick(); tick();
    chk_obs(1'b1, 3'd2, "req_src2");
    ack();
    chk_reg(32'h8, 32'h4, "isr_src2_svc");
    tick();
    src_irq = 4'b0101;
    tick(); tick();
`ifdef IRQ_CTRL_NEST_EN
    chk_obs(1'b1, 3'd0, "nest_req0");
    ack();
    chk_reg(32'h8, 32'h5, "nest_isr5");
    wr(32'h10, 32'h0);
    chk_reg(32'h8, 32'h4, "nest_eoi_isr4");
    wr(32'h10, 32'h0);
    chk_reg(32'h8, 32'h0, "nest_eoi_isr0");
`else
    chk_obs(1'b0, 3'd2, "no_nest_req");
    chk_reg(32'h4, 32'h1, "no_nest_ipr");
    wr(32'h10, 32'h0);
    chk_obs(1'b0, 3'd2, "no_nest_idle");
    chk_obs(1'b1, 3'd0, "no_nest_then_req0");
    ack();
    chk_reg(32'h8, 32'h1, "no_nest_isr1");
    wr(32'h10, 32'h0);
    chk_reg(32'h8, 32'h0, "no_nest_isr0");
`endif
    src_irq = '0;

    // Edge coincident with write-1-clear of the same bit: set wins
    wr(32'h0, 32'h0);
    tick();
    src_irq = 4'b0010;
    wr(32'h4, 32'h2);
    chk_reg(32'h4, 32'h2, "set_beats_w1c");
    wr(32'h4, 32'h2);
    chk_reg(32'h4, 32'h0, "w1c_plain");

    // Asynchronous reset while requesting
    src_irq = '0;
    tick();
    wr(32'h0, 32'h2);
    src_irq = 4'b0010;
    tick(); tick();
    chk_obs(1'b1, 3'd1, "req_before_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    chk_obs(1'b0, 3'd0, "async_reset_drop");
    chk_reg(32'h0, 32'h0, "reset_ier");
    chk_reg(32'h4, 32'h0, "reset_ipr");
    chk_reg(32'h8, 32'h0, "reset_isr");
    chk_reg(32'hC, 32'h0, "reset_vec");
    tick();
    reset = 1'b0;

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
